fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the next-generation core. It replaces the single-cycle core's combinational PC-to-instruction-memory path. It owns the PC, issues in-order requests to an instruction memory with variable latency, and buffers returned instructions in a DEPTH-entry queue. It presents the instructions to decode over a valid/ready handshake, and supports flush-and-redirect for taken branches, JAL and JALR.

---
 rtl/fetch_queue_pkg.sv | 27 ++
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
// The optional FETCH_BYPASS_EN build is selected in fetch_queue.sv.
package fetch_queue_pkg;

   localparam int PC_STEP         = 4;
   localparam int DEF_BITNESS     = 32;
   localparam int DEF_INSTR_WIDTH = 32;
   localparam int DEF_DEPTH       = 4;

   // Pointer width indexes DEPTH slots; counter width must also represent DEPTH itself.
   localparam int PTR_W = $clog2(DEF_DEPTH);
   localparam int CNT_W = $clog2(DEF_DEPTH + 1);

   typedef struct packed {
      logic [DEF_BITNESS-1:0]     pc;
      logic [DEF_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory port and the decode-side port of fetch_queue.
// Handshakes: a transfer happens in a cycle where both sides are high at the rising
// edge (imem_req_o & imem_gnt_i, valid_o & ready_i); the source never waits on ready.
interface fetch_queue_if #(
   parameter int BITNESS     = 32,
   parameter int INSTR_WIDTH = 32
);

   logic                   imem_req_o;
   logic [BITNESS-1:0]     imem_addr_o;
   logic                   imem_gnt_i;
   logic                   imem_rvalid_i;
   logic [INSTR_WIDTH-1:0] imem_rdata_i;
   logic                   redirect_i;
   logic [BITNESS-1:0]     redirect_pc_i;
   logic                   valid_o;
   logic                   ready_i;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [BITNESS-1:0]     pc_o;
   logic [BITNESS-1:0]     pcplus4_o;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  redirect_i, redirect_pc_i,
      output valid_o,
      input  ready_i,
      output instr_o, pc_o, pcplus4_o
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output redirect_i, redirect_pc_i,
      input  valid_o,
      output ready_i,
      input  instr_o, pc_o, pcplus4_o
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage array
// so the output depends only on registered state.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 4,
   localparam int PW      = ptr_width(DEPTH),
   localparam int CW      = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   output entry_t        head,
   output logic [CW-1:0] count
);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & (count != '0);
   // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
   assign do_push = push & (!full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order fetches, buffers responses.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                 BITNESS     = 32,
   parameter int                 INSTR_WIDTH = 32,
   parameter int                 DEPTH       = 4,
   parameter logic [BITNESS-1:0] RESET_PC    = '0
) (
   input logic           clk_i,
   input logic           rst_i,
   fetch_queue_if.master bus
);

   localparam int CW = cnt_width(DEPTH);

   typedef struct packed {
      logic [BITNESS-1:0]     pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   typedef logic [BITNESS-1:0] tag_t;

   logic [BITNESS-1:0] fetch_pc;
   logic [CW-1:0]      out_cnt;
   logic [CW-1:0]      disc_cnt;
   logic [CW-1:0]      occupancy;
   logic [CW-1:0]      tag_count;
   logic [CW:0]        in_use;
   logic               grant;
   logic               rvalid_eff;
   logic               resp_ok;
   logic               bypass;
   logic               bypass_take;
   logic               enq;
   logic               deq;
   logic               q_empty;
   entry_t             resp_entry;
   entry_t             q_head;
   entry_t             head;
   tag_t               tag_head;
   logic [1:0]         unused_pc_bits;

   assign unused_pc_bits = bus.redirect_pc_i[1:0];

   // Queue slots plus in-flight requests never exceed DEPTH, so every response has a slot.
   assign in_use          = {1'b0, occupancy} + {1'b0, out_cnt};
   assign bus.imem_req_o  = !rst_i && !bus.redirect_i && (in_use < (CW+1)'(DEPTH));
   assign bus.imem_addr_o = fetch_pc;
   assign grant           = bus.imem_req_o & bus.imem_gnt_i;

   // A response with nothing outstanding belongs to a pre-reset request and is ignored.
   assign rvalid_eff = bus.imem_rvalid_i & (out_cnt != '0);
   assign resp_ok    = rvalid_eff & (disc_cnt == '0) & !bus.redirect_i;
   assign q_empty    = (occupancy == '0);
   assign resp_entry = '{pc: tag_head, instr: bus.imem_rdata_i};

`ifdef FETCH_BYPASS_EN
   assign bypass = resp_ok & q_empty;
`else
   assign bypass = 1'b0;
`endif

   assign bypass_take = bypass & bus.ready_i;
   assign enq         = resp_ok & !bypass_take;
   assign deq         = !q_empty & bus.ready_i;

   fetch_fifo #(
      .entry_t (tag_t),
      .DEPTH   (DEPTH)
   ) u_tag_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (bus.redirect_i),
      .push      (grant),
      .push_data (fetch_pc),
      .pop       (resp_ok & (tag_count != '0)),
      .head      (tag_head),
      .count     (tag_count)
   );

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_instr_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (bus.redirect_i),
      .push      (enq),
      .push_data (resp_entry),
      .pop       (deq),
      .head      (q_head),
      .count     (occupancy)
   );

   // Idle outputs read as zero so pcplus4_o shows PC_STEP when nothing is valid.
   assign head          = bypass ? resp_entry : q_head;
   assign bus.valid_o   = !q_empty | bypass;
   assign bus.instr_o   = bus.valid_o ? head.instr : '0;
   assign bus.pc_o      = bus.valid_o ? head.pc : '0;
   assign bus.pcplus4_o = bus.pc_o + BITNESS'(PC_STEP);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc <= RESET_PC;
         out_cnt  <= '0;
         disc_cnt <= '0;
      end else begin
         out_cnt <= out_cnt + CW'(grant) - CW'(rvalid_eff);
         if (bus.redirect_i) begin
            // Everything still in flight, minus a response landing now, is stale.
            fetch_pc <= {bus.redirect_pc_i[BITNESS-1:2], 2'b00};
            disc_cnt <= out_cnt - CW'(rvalid_eff);
         end else begin
            if (grant) fetch_pc <= fetch_pc + BITNESS'(PC_STEP);
            if (rvalid_eff && disc_cnt != '0) disc_cnt <= disc_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table for reset/fill/backpressure/wrap,
// then hand sequences for redirect corners; a second instance starts near the top of memory.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.BITNESS(32), .INSTR_WIDTH(32)) bus ();
   fetch_queue_if #(.BITNESS(32), .INSTR_WIDTH(32)) bus_w ();

   fetch_queue #(.BITNESS(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
   );

   fetch_queue #(.BITNESS(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_w.master)
   );

   assign bus_w.imem_gnt_i    = bus.imem_gnt_i;
   assign bus_w.imem_rvalid_i = bus.imem_rvalid_i;
   assign bus_w.imem_rdata_i  = bus.imem_rdata_i;
   assign bus_w.redirect_i    = bus.redirect_i;
   assign bus_w.redirect_pc_i = bus.redirect_pc_i;
   assign bus_w.ready_i       = bus.ready_i;

   // memory model: in-order responses, each due lat cycles after its grant
   logic [31:0] mem_q [$];
   int          due_q [$];
   logic [31:0] exp_q [$];
   int          cyc;
   int          lat;
   int          n_checks;
   int          n_fail;

   logic        s_req, s_valid, w_valid;
   logic [31:0] s_addr, s_pc, s_instr, s_p4, w_addr, w_pc, w_p4;

   vec_t fill_v [13];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(input logic r, g, rdy, req, input logic [31:0] addr,
                               input logic v, input logic [31:0] pc);
      vec_t t;
      t.rst = r; t.gnt = g; t.ready = rdy; t.exp_req = req;
      t.exp_addr = addr; t.exp_valid = v; t.exp_pc = pc;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // called at a falling edge: drive, sample outputs, update the model, advance one cycle
   task automatic run_cycle(input logic r, input logic g, input logic rdy,
                            input logic redir, input logic [31:0] rpc);
      rst               = r;
      bus.imem_gnt_i    = g;
      bus.ready_i       = rdy;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      if (!r && mem_q.size() > 0 && due_q[0] <= cyc) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = instr_of(mem_q[0]);
      end else begin
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = 32'h0;
      end
      #1;
      s_req = bus.imem_req_o;  s_addr = bus.imem_addr_o; s_valid = bus.valid_o;
      s_pc = bus.pc_o; s_instr = bus.instr_o; s_p4 = bus.pcplus4_o;
      w_addr = bus_w.imem_addr_o; w_valid = bus_w.valid_o; w_pc = bus_w.pc_o; w_p4 = bus_w.pcplus4_o;
      if (r) begin
         mem_q.delete();
         due_q.delete();
      end else begin
         if (bus.imem_rvalid_i) begin
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
         end
         if (s_req && g) begin
            mem_q.push_back(s_addr);
            due_q.push_back(cyc + lat);
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        found;
      int          wait_n;
      logic [31:0] f_pc, f_instr, w_exp_pc, exp_instr;
      n_checks = 0; n_fail = 0; cyc = 0; lat = 1;
      bus.imem_gnt_i = 1'b0; bus.ready_i = 1'b0; bus.redirect_i = 1'b0;
      bus.redirect_pc_i = 32'h0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;

      // reset, fill with latency 1 under backpressure, then drain at full rate
      fill_v[0]  = mk(1, 1, 0, 0, 32'h00, 0,   32'h00);
      fill_v[1]  = mk(1, 1, 0, 0, 32'h00, 0,   32'h00);
      fill_v[2]  = mk(1, 1, 0, 0, 32'h00, 0,   32'h00);
      fill_v[3]  = mk(0, 1, 0, 1, 32'h00, 0,   32'h00);
      fill_v[4]  = mk(0, 1, 0, 1, 32'h04, BYP, 32'h00);
      fill_v[5]  = mk(0, 1, 0, 1, 32'h08, 1,   32'h00);
      fill_v[6]  = mk(0, 1, 0, 1, 32'h0C, 1,   32'h00);
      fill_v[7]  = mk(0, 1, 0, 0, 32'h10, 1,   32'h00);
      fill_v[8]  = mk(0, 1, 1, 0, 32'h10, 1,   32'h00);
      fill_v[9]  = mk(0, 1, 1, 1, 32'h10, 1,   32'h04);
      fill_v[10] = mk(0, 1, 1, 1, 32'h14, 1,   32'h08);
      fill_v[11] = mk(0, 1, 1, 1, 32'h18, 1,   32'h0C);
      fill_v[12] = mk(0, 1, 1, 1, 32'h1C, 1,   32'h10);
      exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
      exp_q.push_back(32'h0C); exp_q.push_back(32'h10);

      @(negedge clk);
      for (int k = 0; k < 13; k++) begin
         run_cycle(fill_v[k].rst, fill_v[k].gnt, fill_v[k].ready, 1'b0, 32'h0);
         exp_instr = fill_v[k].exp_valid ? instr_of(fill_v[k].exp_pc) : 32'h0;
         w_exp_pc  = fill_v[k].exp_valid ? fill_v[k].exp_pc - 32'h8 : 32'h0;
         check($sformatf("fill[%0d].req", k),    s_req,   fill_v[k].exp_req);
         check($sformatf("fill[%0d].addr", k),   s_addr,  fill_v[k].exp_addr);
         check($sformatf("fill[%0d].valid", k),  s_valid, fill_v[k].exp_valid);
         check($sformatf("fill[%0d].pc", k),     s_pc,    fill_v[k].exp_pc);
         check($sformatf("fill[%0d].instr", k),  s_instr, exp_instr);
         check($sformatf("fill[%0d].pc4", k),    s_p4,    fill_v[k].exp_pc + 32'h4);
         check($sformatf("wrap[%0d].addr", k),   w_addr,  fill_v[k].exp_addr - 32'h8);
         check($sformatf("wrap[%0d].valid", k),  w_valid, fill_v[k].exp_valid);
         check($sformatf("wrap[%0d].pc", k),     w_pc,    w_exp_pc);
         check($sformatf("wrap[%0d].pc4", k),    w_p4,    w_exp_pc + 32'h4);
         if (s_valid && fill_v[k].ready) begin
            if (exp_q.size() == 0) begin
               check($sformatf("sb[%0d].unexpected", k), s_pc, 32'hDEAD_BEEF);
            end else begin
               check($sformatf("sb[%0d].pc", k), s_pc, exp_q.pop_front());
            end
         end
      end
      check("sb.drained", exp_q.size(), 0);

      // redirect with three requests in flight at latency 3 (mid-operation reset first)
      lat = 3;
      run_cycle(1, 0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         run_cycle(0, 1, 1, 0, 32'h0);
         check($sformatf("redir.pre[%0d].valid", i), s_valid, 1'b0);
      end
      run_cycle(0, 1, 1, 1, 32'h103);
      check("redir.req_in_redirect", s_req, 1'b0);
      found = 1'b0; wait_n = -1; f_pc = 32'h0; f_instr = 32'h0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(0, 1, 1, 0, 32'h0);
         if (s_valid) begin
            found = 1'b1; wait_n = i; f_pc = s_pc; f_instr = s_instr;
         end
      end
      check("redir.found", found, 1'b1);
      check("redir.latency", wait_n, BYP ? 3 : 4);
      check("redir.pc", f_pc, 32'h100);
      check("redir.instr", f_instr, instr_of(32'h100));

      // redirect coinciding with a response and a dequeue
      lat = 1;
      run_cycle(1, 0, 0, 0, 32'h0);
      run_cycle(0, 1, 0, 0, 32'h0);
      check("coin.reset_addr", s_addr, 32'h0);
      check("coin.reset_valid", s_valid, 1'b0);
      run_cycle(0, 1, 0, 0, 32'h0);
      run_cycle(0, 1, 1, 1, 32'h200);
      check("coin.deq_valid", s_valid, 1'b1);
      check("coin.deq_pc", s_pc, 32'h0);
      check("coin.deq_instr", s_instr, instr_of(32'h0));
      check("coin.req", s_req, 1'b0);
      run_cycle(0, 1, 1, 0, 32'h0);
      check("coin.after_valid", s_valid, 1'b0);
      check("coin.after_addr", s_addr, 32'h200);
      check("coin.after_req", s_req, 1'b1);

      // response into an empty queue with decode ready
      run_cycle(0, 0, 1, 0, 32'h0);
      check("bypass.valid", s_valid, BYP);
      check("bypass.pc", s_pc, BYP ? 32'h200 : 32'h0);
      check("bypass.occupancy", dut.occupancy, BYP ? 3'd0 : 3'd1);
      run_cycle(0, 0, 1, 0, 32'h0);
      check("bypass.next_valid", s_valid, !BYP);
      check("bypass.next_pc", s_pc, BYP ? 32'h0 : 32'h200);
      check("bypass.next_pc4", s_p4, BYP ? 32'h4 : 32'h204);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
